// File: rtl/gshare_branch_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the gshare branch predictor.
// The pipeline side is the master; the predictor is the slave.
interface gshare_branch_predictor_if #(
    parameter int GHR_LEN = 8
);
    logic [31:0]        PC;
    logic               fetch_valid;
    logic               predict_taken;
    logic [31:0]        predict_target;
    logic [GHR_LEN-1:0] predict_ghr;
    logic               is_branch;
    logic [31:0]        update_PC;
    logic [GHR_LEN-1:0] update_ghr;
    logic               real_taken;
    logic [31:0]        real_target;
    logic               predict_wrong;

    modport master (
        output PC, fetch_valid, is_branch, update_PC, update_ghr,
               real_taken, real_target, predict_wrong,
        input  predict_taken, predict_target, predict_ghr
    );

    modport slave (
        input  PC, fetch_valid, is_branch, update_PC, update_ghr,
               real_taken, real_target, predict_wrong,
        output predict_taken, predict_target, predict_ghr
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage predictor: direct-mapped tagged BTB plus a table of 2-bit counters
// indexed by PC XOR global history (or PC alone), with GHR snapshot recovery.
module gshare_branch_predictor #(
    parameter int         BTB_ADDR_LEN = 8,
    parameter int         PHT_ADDR_LEN = 10,
    parameter int         GHR_LEN      = 8,
    parameter bit         USE_GSHARE   = 1'b1,
    parameter logic [1:0] CNT_INIT     = 2'b01
) (
    input  logic                      clk,
    input  logic                      rst_n,
    gshare_branch_predictor_if.slave  bp
);
    localparam int BTB_DEPTH = 1 << BTB_ADDR_LEN;
    localparam int PHT_DEPTH = 1 << PHT_ADDR_LEN;
    localparam int TAG_LEN   = 30 - BTB_ADDR_LEN;

    logic [BTB_DEPTH-1:0] btb_valid_q, btb_valid_d;
    logic [TAG_LEN-1:0]   btb_tag_q    [BTB_DEPTH];
    logic [TAG_LEN-1:0]   btb_tag_d    [BTB_DEPTH];
    logic [31:0]          btb_target_q [BTB_DEPTH];
    logic [31:0]          btb_target_d [BTB_DEPTH];
    logic [1:0]           pht_q        [PHT_DEPTH];
    logic [1:0]           pht_d        [PHT_DEPTH];
    logic [GHR_LEN-1:0]   ghr_q, ghr_d;

    logic [BTB_ADDR_LEN-1:0] fetch_btb_idx, upd_btb_idx;
    logic [PHT_ADDR_LEN-1:0] fetch_pht_idx, upd_pht_idx;
    logic                    btb_hit;
    logic                    taken;
    logic [1:0]              upd_cnt;
    logic                    unused_low_bits;

    function automatic logic [PHT_ADDR_LEN-1:0] pht_index(
        input logic [31:0]        pc,
        input logic [GHR_LEN-1:0] hist
    );
        if (USE_GSHARE)
            return pc[PHT_ADDR_LEN+1:2] ^ PHT_ADDR_LEN'(hist);
        else
            return pc[PHT_ADDR_LEN+1:2];
    endfunction

    // Widening before truncation keeps this legal for GHR_LEN == 1.
    function automatic logic [GHR_LEN-1:0] shift_in(
        input logic [GHR_LEN-1:0] hist,
        input logic               dir
    );
        logic [GHR_LEN:0] tmp;
        tmp = {hist, dir};
        return tmp[GHR_LEN-1:0];
    endfunction

    assign unused_low_bits = ^{bp.PC[1:0], bp.update_PC[1:0]};

    always_comb begin
        fetch_btb_idx = bp.PC[BTB_ADDR_LEN+1:2];
        upd_btb_idx   = bp.update_PC[BTB_ADDR_LEN+1:2];
        fetch_pht_idx = pht_index(bp.PC, ghr_q);
        upd_pht_idx   = pht_index(bp.update_PC, bp.update_ghr);
        btb_hit       = btb_valid_q[fetch_btb_idx] &&
                        (btb_tag_q[fetch_btb_idx] == bp.PC[31:BTB_ADDR_LEN+2]);
        taken         = btb_hit && pht_q[fetch_pht_idx][1];
    end

    assign bp.predict_taken  = taken;
    assign bp.predict_target = taken ? btb_target_q[fetch_btb_idx] : bp.PC + 32'd4;
    assign bp.predict_ghr    = ghr_q;

    // Recovery is applied last so it overrides a same-cycle speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (bp.fetch_valid && btb_hit)
            ghr_d = shift_in(ghr_q, taken);
        if (bp.is_branch && bp.predict_wrong)
            ghr_d = shift_in(bp.update_ghr, bp.real_taken);
    end

    always_comb begin
        pht_d   = pht_q;
        upd_cnt = pht_q[upd_pht_idx];
        if (bp.is_branch) begin
            if (bp.real_taken && upd_cnt != 2'b11)
                upd_cnt = upd_cnt + 2'b01;
            else if (!bp.real_taken && upd_cnt != 2'b00)
                upd_cnt = upd_cnt - 2'b01;
            pht_d[upd_pht_idx] = upd_cnt;
        end
    end

    // Only taken branches allocate; a not-taken branch leaves the BTB untouched.
    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        if (bp.is_branch && bp.real_taken) begin
            btb_valid_d[upd_btb_idx]  = 1'b1;
            btb_tag_d[upd_btb_idx]    = bp.update_PC[31:BTB_ADDR_LEN+2];
            btb_target_d[upd_btb_idx] = bp.real_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q       <= '0;
            btb_valid_q <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
            for (int i = 0; i < PHT_DEPTH; i++)
                pht_q[i] <= CNT_INIT;
        end else begin
            ghr_q        <= ghr_d;
            btb_valid_q  <= btb_valid_d;
            btb_tag_q    <= btb_tag_d;
            btb_target_q <= btb_target_d;
            pht_q        <= pht_d;
        end
    end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench: a bimodal instance for table/GHR behaviour, and a gshare
// instance showing that history changes which counter a lookup uses.
module tb_gshare_branch_predictor;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gshare_branch_predictor_if #(.GHR_LEN(8)) bm ();
    gshare_branch_predictor_if #(.GHR_LEN(8)) gs ();

    gshare_branch_predictor #(.USE_GSHARE(1'b0)) dut_bim (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bm)
    );

    gshare_branch_predictor #(.USE_GSHARE(1'b1)) dut_gs (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (gs)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bm.PC = '0; bm.fetch_valid = 0; bm.is_branch = 0; bm.update_PC = '0;
        bm.update_ghr = '0; bm.real_taken = 0; bm.real_target = '0; bm.predict_wrong = 0;
        gs.PC = '0; gs.fetch_valid = 0; gs.is_branch = 0; gs.update_PC = '0;
        gs.update_ghr = '0; gs.real_taken = 0; gs.real_target = '0; gs.predict_wrong = 0;
    endtask

    task automatic bm_resolve(input logic [31:0] pc, input logic tk,
                              input logic [31:0] tgt, input logic wrong,
                              input logic [7:0] ghr);
        bm.is_branch = 1; bm.update_PC = pc; bm.real_taken = tk;
        bm.real_target = tgt; bm.predict_wrong = wrong; bm.update_ghr = ghr;
    endtask

    task automatic test_reset();
        idle_all();
        #2 rst_n = 1'b0;
        bm.PC = 32'h100;
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target, bm.predict_ghr} !== {1'b0, 32'h104, 8'h00}) begin
            errors++;
            $display("FAIL reset_out: got %h want %h", {bm.predict_taken, bm.predict_target, bm.predict_ghr}, {1'b0, 32'h104, 8'h00});
        end
        tick();
        tick();
        rst_n = 1'b1;
        bm.fetch_valid = 1; bm.PC = 32'h100;
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target, bm.predict_ghr} !== {1'b0, 32'h104, 8'h00}) begin
            errors++;
            $display("FAIL first_fetch: got %h want %h", {bm.predict_taken, bm.predict_target, bm.predict_ghr}, {1'b0, 32'h104, 8'h00});
        end
        tick();
        checks++;
        if (bm.predict_ghr !== 8'h00) begin
            errors++;
            $display("FAIL miss_no_shift: got ghr=%h want ghr=00", bm.predict_ghr);
        end
        bm.PC = 32'hFFFF_FFFC;
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL pc4_wrap: got %h want %h", {bm.predict_taken, bm.predict_target}, {1'b0, 32'h0});
        end
        bm.fetch_valid = 0;
    endtask

    task automatic test_train_taken();
        bm.PC = 32'h100;
        bm_resolve(32'h100, 1'b1, 32'h200, 1'b1, 8'h00);
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target} !== {1'b0, 32'h104}) begin
            errors++;
            $display("FAIL no_bypass: got %h want %h", {bm.predict_taken, bm.predict_target}, {1'b0, 32'h104});
        end
        tick();
        checks++;
        if ({bm.predict_taken, bm.predict_target, bm.predict_ghr} !== {1'b1, 32'h200, 8'h01}) begin
            errors++;
            $display("FAIL after_one_update: got %h want %h", {bm.predict_taken, bm.predict_target, bm.predict_ghr}, {1'b1, 32'h200, 8'h01});
        end
        tick();
        tick();
        bm.is_branch = 0;
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target, bm.predict_ghr} !== {1'b1, 32'h200, 8'h01}) begin
            errors++;
            $display("FAIL trained_taken: got %h want %h", {bm.predict_taken, bm.predict_target, bm.predict_ghr}, {1'b1, 32'h200, 8'h01});
        end
    endtask

    task automatic test_saturation();
        // counter walks 3 -> 2 -> 1 -> 0 -> 0
        logic exp_tk [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] exp_tgt;
        bm.PC = 32'h100;
        bm_resolve(32'h100, 1'b0, 32'h0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_tgt = exp_tk[i] ? 32'h200 : 32'h104;
            checks++;
            if ({bm.predict_taken, bm.predict_target, bm.predict_ghr} !== {exp_tk[i], exp_tgt, 8'h01}) begin
                errors++;
                $display("FAIL sat_step%0d: got %h want %h", i, {bm.predict_taken, bm.predict_target, bm.predict_ghr}, {exp_tk[i], exp_tgt, 8'h01});
            end
        end
        bm.is_branch = 0;
    endtask

    task automatic test_ghr();
        bm_resolve(32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
        tick();
        tick();
        bm_resolve(32'h100, 1'b1, 32'h200, 1'b1, 8'h52);
        tick();
        bm.is_branch = 0;
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target, bm.predict_ghr} !== {1'b1, 32'h200, 8'hA5}) begin
            errors++;
            $display("FAIL recover_a5: got %h want %h", {bm.predict_taken, bm.predict_target, bm.predict_ghr}, {1'b1, 32'h200, 8'hA5});
        end
        bm.predict_wrong = 1; bm.update_ghr = 8'h00;
        tick();
        bm.predict_wrong = 0;
        checks++;
        if (bm.predict_ghr !== 8'hA5) begin
            errors++;
            $display("FAIL ignore_no_branch: got ghr=%h want ghr=a5", bm.predict_ghr);
        end
        bm.fetch_valid = 1; bm.PC = 32'h100;
        tick();
        checks++;
        if (bm.predict_ghr !== 8'h4B) begin
            errors++;
            $display("FAIL spec_shift: got ghr=%h want ghr=4b", bm.predict_ghr);
        end
        bm.PC = 32'h104;
        tick();
        checks++;
        if ({bm.predict_taken, bm.predict_target, bm.predict_ghr} !== {1'b0, 32'h108, 8'h4B}) begin
            errors++;
            $display("FAIL miss_hold: got %h want %h", {bm.predict_taken, bm.predict_target, bm.predict_ghr}, {1'b0, 32'h108, 8'h4B});
        end
        bm.PC = 32'h100;
        bm_resolve(32'h300, 1'b0, 32'h0, 1'b1, 8'h0F);
        tick();
        bm.is_branch = 0; bm.predict_wrong = 0; bm.fetch_valid = 0;
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target, bm.predict_ghr} !== {1'b1, 32'h200, 8'h1E}) begin
            errors++;
            $display("FAIL recover_wins: got %h want %h", {bm.predict_taken, bm.predict_target, bm.predict_ghr}, {1'b1, 32'h200, 8'h1E});
        end
        tick();
        checks++;
        if (bm.predict_ghr !== 8'h1E) begin
            errors++;
            $display("FAIL no_fetch_no_shift: got ghr=%h want ghr=1e", bm.predict_ghr);
        end
    endtask

    task automatic test_alias();
        bm.PC = 32'h500;
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target} !== {1'b0, 32'h504}) begin
            errors++;
            $display("FAIL alias_miss: got %h want %h", {bm.predict_taken, bm.predict_target}, {1'b0, 32'h504});
        end
        bm_resolve(32'h500, 1'b1, 32'h600, 1'b0, 8'h00);
        tick();
        tick();
        bm.is_branch = 0;
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target} !== {1'b1, 32'h600}) begin
            errors++;
            $display("FAIL alias_trained: got %h want %h", {bm.predict_taken, bm.predict_target}, {1'b1, 32'h600});
        end
        bm.PC = 32'h100;
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target} !== {1'b0, 32'h104}) begin
            errors++;
            $display("FAIL alias_evict: got %h want %h", {bm.predict_taken, bm.predict_target}, {1'b0, 32'h104});
        end
    endtask

    task automatic test_async_reset();
        bm_resolve(32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
        tick();
        bm.is_branch = 0;
        bm.PC = 32'h100;
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target, bm.predict_ghr} !== {1'b1, 32'h200, 8'h1E}) begin
            errors++;
            $display("FAIL pre_reset_hit: got %h want %h", {bm.predict_taken, bm.predict_target, bm.predict_ghr}, {1'b1, 32'h200, 8'h1E});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target, bm.predict_ghr} !== {1'b0, 32'h104, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", {bm.predict_taken, bm.predict_target, bm.predict_ghr}, {1'b0, 32'h104, 8'h00});
        end
        tick();
        rst_n = 1'b1;
        bm.fetch_valid = 1;
        #1;
        checks++;
        if ({bm.predict_taken, bm.predict_target, bm.predict_ghr} !== {1'b0, 32'h104, 8'h00}) begin
            errors++;
            $display("FAIL post_reset_fetch: got %h want %h", {bm.predict_taken, bm.predict_target, bm.predict_ghr}, {1'b0, 32'h104, 8'h00});
        end
        tick();
        bm.fetch_valid = 0;
        checks++;
        if (bm.predict_ghr !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_ghr: got ghr=%h want ghr=00", bm.predict_ghr);
        end
    endtask

    task automatic test_gshare_index();
        // Train the counter at (0x100>>2)^3 = 0x43; the GHR=0 lookup uses 0x40.
        gs.is_branch = 1; gs.update_PC = 32'h100; gs.update_ghr = 8'h03;
        gs.real_taken = 1; gs.real_target = 32'h200; gs.predict_wrong = 0;
        tick();
        tick();
        gs.is_branch = 0;
        gs.PC = 32'h100;
        #1;
        checks++;
        if ({gs.predict_taken, gs.predict_target, gs.predict_ghr} !== {1'b0, 32'h104, 8'h00}) begin
            errors++;
            $display("FAIL gshare_ghr0: got %h want %h", {gs.predict_taken, gs.predict_target, gs.predict_ghr}, {1'b0, 32'h104, 8'h00});
        end
        gs.is_branch = 1; gs.predict_wrong = 1; gs.update_ghr = 8'h01;
        tick();
        gs.is_branch = 0; gs.predict_wrong = 0;
        #1;
        checks++;
        if ({gs.predict_taken, gs.predict_target, gs.predict_ghr} !== {1'b1, 32'h200, 8'h03}) begin
            errors++;
            $display("FAIL gshare_ghr3: got %h want %h", {gs.predict_taken, gs.predict_target, gs.predict_ghr}, {1'b1, 32'h200, 8'h03});
        end
    endtask

    initial begin
        test_reset();
        test_train_taken();
        test_saturation();
        test_ghr();
        test_alias();
        test_async_reset();
        test_gshare_index();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
- Parametrised next-generation fetch-stage predictor: direct-mapped tagged BTB plus a PHT of 2-bit saturating counters.
- The PHT is indexed by PC XOR a global history register (gshare), or by PC alone (bimodal mode).
- Prediction is combinational in the IF stage. Resolved branches from EX update the tables. Mispredicts restore the GHR from the snapshot carried down the pipe.

Parameters:
- BTB_ADDR_LEN, 8: log2 BTB entries. Index PC[BTB_ADDR_LEN+1:2]; tag PC[31:BTB_ADDR_LEN+2].
- PHT_ADDR_LEN, 10: log2 PHT entries.
- GHR_LEN, 8: history bits. Legal range 1..PHT_ADDR_LEN.
- USE_GSHARE, 1: 1 = index PHT with PC XOR GHR; 0 = PC only (GHR still maintained).
- CNT_INIT, 2'b01: counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PC  in  32  fetch PC.
- fetch_valid  in  1  IF stage advancing this cycle; gates speculative GHR shift.
- predict_taken  out  1  predicted taken.
- predict_target  out  32  BTB target if predict_taken, else PC+4.
- predict_ghr  out  GHR_LEN  GHR value used for this lookup; carried to EX.
- is_branch  in  1  EX resolving a conditional branch/jump this cycle.
- update_PC  in  32  PC of resolving branch.
- update_ghr  in  GHR_LEN  predict_ghr snapshot of that branch.
- real_taken  in  1  resolved direction.
- real_target  in  32  resolved target.
- predict_wrong  in  1  direction or target mispredicted; valid only with is_branch.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all BTB valid bits 0; all PHT counters CNT_INIT; GHR 0.
  - Outputs during reset: predict_taken 0, predict_target PC+4, predict_ghr 0.
- Lookup (combinational, zero latency):
  - btb_hit = valid[idx] & tag match.
  - pht_idx = PC[PHT_ADDR_LEN+1:2] XOR zero-extended GHR (USE_GSHARE=1), else PC[PHT_ADDR_LEN+1:2].
  - predict_taken = btb_hit & counter[pht_idx][1].
  - predict_target = btb_target[idx] when predict_taken, else PC+4 (32-bit wrap).
- Speculative GHR: on a clock edge with fetch_valid & btb_hit, GHR <= {GHR[GHR_LEN-2:0], predict_taken}. No shift on a BTB miss.
- Recovery: on is_branch & predict_wrong, GHR <= {update_ghr[GHR_LEN-2:0], real_taken}. Recovery overrides the same-cycle speculative shift.
- PHT update on is_branch:
  - Counter at index update_PC[PHT_ADDR_LEN+1:2] XOR update_ghr (or PC-only in bimodal mode).
  - Increments on real_taken, saturating at 3; decrements otherwise, saturating at 0.
- BTB update on is_branch & real_taken: write valid=1, tag, target=real_target. A not-taken branch never allocates or invalidates.
- Same-cycle update and lookup of one entry: lookup sees the pre-update value; the new value is visible next cycle. No bypass.
- is_branch=0: predict_wrong, real_* and update_* are ignored.
- Reset asserted mid-operation clears all state immediately. The first post-reset fetch predicts not-taken.

Test Plan:
1. Reset, then PC=0x100 with fetch_valid=1 -> predict_taken=0, predict_target=0x104, predict_ghr=0; GHR stays 0 (BTB miss).
2. USE_GSHARE=0. Resolve update_PC=0x100, real_taken=1, real_target=0x200, predict_wrong=1, three times -> counter goes 1→2→3. Next lookup PC=0x100: predict_taken=1, predict_target=0x200.
3. Saturation: from state 3, apply three not-taken updates -> counter 2,1,0. A fourth update keeps it at 0. Lookup predict_taken=0, target 0x104.
4. GHR speculate/recover with GHR_LEN=8, GHR=8'hA5:
   - Hit predicting taken with fetch_valid=1 -> GHR=8'h4B.
   - Same cycle as a fetch hit: is_branch=1, predict_wrong=1, update_ghr=8'h0F, real_taken=0 -> GHR=8'h1E (recovery wins).
5. Tag aliasing: train 0x100 taken to 0x200, then lookup 0x500 (same index when BTB_ADDR_LEN=8, different tag) -> predict_taken=0. Train 0x500 taken to 0x600 -> 0x100 now misses.
6. Assert rst_n low asynchronously mid-run after training -> all outputs immediately at reset values; first post-reset lookup of 0x100 gives predict_taken=0.
